rx_demux: RTL

Receive-side counterpart of the transmit multiplexer: consumes the byte stream from the UART receiver, hunts for a sync byte, assembles an order record (system address, buy/sell code, 32-bit timestamp), verifies it, and delivers it to one of `NUM_SYS` trading systems with a one-cycle valid pulse. It sits between the UART RX core and the per-stock trading systems. Malformed, timed-out and mis-addressed frames are dropped and counted.

---
 rtl/hft_rx_pkg.sv | 37 +++
 rtl/rx_demux_if.sv | 39 +++
 rtl/rx_gap_timer.sv | 36 +++
 rtl/rx_demux.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hft_rx_pkg.sv
// Shared receive-side types and constants for the order-record demultiplexer.
// rx_record_t is the same record layout the transmit multiplexer serialises.
package hft_rx_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN_CHK     = 8;
    localparam int         FRAME_LEN_NOCHK   = 7;

    typedef enum logic [3:0] {
        ST_HUNT,
        ST_ADDR,
        ST_BS,
        ST_TS3,
        ST_TS2,
        ST_TS1,
        ST_TS0,
        ST_CHK,
        ST_DELIVER
    } rx_state_e;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  buysell;
        logic [31:0] timestamp;
    } rx_record_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // XOR over every payload byte of a record (ADDR through TS[7:0]).
    function automatic logic [7:0] record_xor(input rx_record_t rec);
        return rec.addr ^ rec.buysell ^ rec.timestamp[31:24] ^ rec.timestamp[23:16]
             ^ rec.timestamp[15:8] ^ rec.timestamp[7:0];
    endfunction

endpackage

// File: rtl/rx_demux_if.sv
// Byte-stream input and delivered-record output bundle of rx_demux.
// slave: the demux itself; master: the UART side plus downstream consumers.
interface rx_demux_if #(
    parameter int NUM_SYS = 4
);
    logic [7:0]         rx_byte;
    logic               rx_byte_dv;
    logic [7:0]         rx_addr;
    logic [7:0]         rx_buysell;
    logic [31:0]        rx_timestamp;
    logic [NUM_SYS-1:0] rx_dv;
    logic [15:0]        err_chk;
    logic [15:0]        err_addr;
    logic [15:0]        err_gap;

    modport master (
        output rx_byte,
        output rx_byte_dv,
        input  rx_addr,
        input  rx_buysell,
        input  rx_timestamp,
        input  rx_dv,
        input  err_chk,
        input  err_addr,
        input  err_gap
    );

    modport slave (
        input  rx_byte,
        input  rx_byte_dv,
        output rx_addr,
        output rx_buysell,
        output rx_timestamp,
        output rx_dv,
        output err_chk,
        output err_addr,
        output err_gap
    );
endinterface

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter: clear on a byte, count while enabled, and flag
// terminal count on the GAP_TIMEOUT-th silent cycle after the last byte.
module rx_gap_timer #(
    parameter int GAP_TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (GAP_TIMEOUT < 2) ? 1 : $clog2(GAP_TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    // count_q holds (cycles since last byte - 1), so tc marks the expiry cycle
    // itself, in which a late byte can still win over the timeout.
    assign tc = (count_q == CW'(GAP_TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/rx_demux.sv
// Frame hunter / record assembler feeding NUM_SYS trading systems.
// Define RX_CHECKSUM_EN to add the trailing XOR checksum byte and err_chk.
module rx_demux
    import hft_rx_pkg::*;
#(
    parameter int         NUM_SYS     = 4,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int         GAP_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    rx_demux_if.slave   bus
);
`ifdef RX_CHECKSUM_EN
    localparam rx_state_e TS0_NEXT = ST_CHK;
`else
    localparam rx_state_e TS0_NEXT = ST_DELIVER;
`endif

    rx_state_e          state_q, state_d;
    rx_record_t         shadow_q, shadow_d;
    rx_record_t         out_q, out_d;
    logic [NUM_SYS-1:0] rx_dv_q, rx_dv_d;
    logic [15:0]        err_addr_q, err_addr_d;
    logic [15:0]        err_gap_q, err_gap_d;

    logic byte_dv;
    logic in_frame;
    logic gap_tc;
    logic chk_fail;
    logic addr_bad;
    logic deliver_ok;

    assign byte_dv  = bus.rx_byte_dv;
    assign in_frame = (state_q != ST_HUNT) && (state_q != ST_DELIVER);
    assign addr_bad = (shadow_q.addr >= 8'(NUM_SYS));

`ifdef RX_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
    logic [15:0] err_chk_q, err_chk_d;

    assign chk_fail = (record_xor(shadow_q) != chk_q);
`else
    assign chk_fail = 1'b0;
`endif

    assign deliver_ok = (state_q == ST_DELIVER) && !chk_fail && !addr_bad;

    rx_gap_timer #(
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (byte_dv),
        .en    (in_frame),
        .tc    (gap_tc)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        out_d      = out_q;
        err_addr_d = err_addr_q;
        err_gap_d  = err_gap_q;
`ifdef RX_CHECKSUM_EN
        chk_d      = chk_q;
        err_chk_d  = err_chk_q;
`endif

        case (state_q)
            ST_HUNT: begin
                if (byte_dv && (bus.rx_byte == SYNC_BYTE)) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (byte_dv) begin
                    shadow_d.addr = bus.rx_byte;
                    state_d       = ST_BS;
                end
            end
            ST_BS: begin
                if (byte_dv) begin
                    shadow_d.buysell = bus.rx_byte;
                    state_d          = ST_TS3;
                end
            end
            ST_TS3: begin
                if (byte_dv) begin
                    shadow_d.timestamp[31:24] = bus.rx_byte;
                    state_d                   = ST_TS2;
                end
            end
            ST_TS2: begin
                if (byte_dv) begin
                    shadow_d.timestamp[23:16] = bus.rx_byte;
                    state_d                   = ST_TS1;
                end
            end
            ST_TS1: begin
                if (byte_dv) begin
                    shadow_d.timestamp[15:8] = bus.rx_byte;
                    state_d                  = ST_TS0;
                end
            end
            ST_TS0: begin
                if (byte_dv) begin
                    shadow_d.timestamp[7:0] = bus.rx_byte;
                    state_d                 = TS0_NEXT;
                end
            end
            ST_CHK: begin
`ifdef RX_CHECKSUM_EN
                if (byte_dv) begin
                    chk_d   = bus.rx_byte;
                    state_d = ST_DELIVER;
                end
`else
                state_d = ST_HUNT;
`endif
            end
            ST_DELIVER: begin
                // Checksum has priority over the address range test.
                state_d = ST_HUNT;
                if (chk_fail) begin
`ifdef RX_CHECKSUM_EN
                    err_chk_d = sat_inc16(err_chk_q);
`endif
                end else if (addr_bad) begin
                    err_addr_d = sat_inc16(err_addr_q);
                end else begin
                    out_d = shadow_q;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // A byte landing in the expiry cycle was already consumed above.
        if (in_frame && gap_tc && !byte_dv) begin
            err_gap_d = sat_inc16(err_gap_q);
            state_d   = ST_HUNT;
        end
    end

    for (genvar gi = 0; gi < NUM_SYS; gi++) begin : g_dv
        assign rx_dv_d[gi] = deliver_ok && (shadow_q.addr == 8'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            shadow_q   <= '0;
            out_q      <= '0;
            rx_dv_q    <= '0;
            err_addr_q <= '0;
            err_gap_q  <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            out_q      <= out_d;
            rx_dv_q    <= rx_dv_d;
            err_addr_q <= err_addr_d;
            err_gap_q  <= err_gap_d;
        end
    end

`ifdef RX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q     <= '0;
            err_chk_q <= '0;
        end else begin
            chk_q     <= chk_d;
            err_chk_q <= err_chk_d;
        end
    end

    assign bus.err_chk = err_chk_q;
`else
    assign bus.err_chk = 16'h0000;
`endif

    assign bus.rx_addr      = out_q.addr;
    assign bus.rx_buysell   = out_q.buysell;
    assign bus.rx_timestamp = out_q.timestamp;
    assign bus.rx_dv        = rx_dv_q;
    assign bus.err_addr     = err_addr_q;
    assign bus.err_gap      = err_gap_q;
endmodule
